// File: rtl/deserializer_if.sv
// Serial-in / parallel-out bus of the deserializer.
//   data_i, data_val_i          : serial bit stream, MSB of each word first
//   deser_data_o                : rebuilt word, first bit at [DATA_W-1]
//   deser_data_mod_o            : valid bit count of deser_data_o (0 = DATA_W)
//   deser_data_val_o, err_o     : one-cycle pulses (new word / short run dropped)
// master drives the serial side; slave is the deserializer itself.
interface deserializer_if #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = 4
);
    logic              data_i;
    logic              data_val_i;
    logic [DATA_W-1:0] deser_data_o;
    logic [MOD_W-1:0]  deser_data_mod_o;
    logic              deser_data_val_o;
    logic              err_o;

    modport master (
        output data_i, data_val_i,
        input  deser_data_o, deser_data_mod_o, deser_data_val_o, err_o
    );

    modport slave (
        input  data_i, data_val_i,
        output deser_data_o, deser_data_mod_o, deser_data_val_o, err_o
    );
endinterface

// File: rtl/deserializer.sv
// Deserializer: collects an MSB-first serial bit stream into DATA_W-bit words.
// A full word is emitted every DATA_W valid bits; when the valid run ends
// early, a partial word (MSB-aligned, zero-filled) is emitted with its bit
// count, or dropped with an err_o pulse if shorter than MIN_BITS.
// Ports:
//   clk_i  : clock, rising edge
//   srst_i : synchronous active-high reset
//   bus    : deserializer_if.slave (serial in, parallel word + pulses out)
module deserializer #(
    parameter int DATA_W   = 16,
    parameter int MOD_W    = 4,
    parameter int MIN_BITS = 3
) (
    input  logic           clk_i,
    input  logic           srst_i,
    deserializer_if.slave  bus
);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [MOD_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [MOD_W-1:0]  mod_q, mod_d;
    logic              val_q, val_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] shreg_nxt;
    logic [MOD_W-1:0]  wr_idx;

    // DATA_W == 2**MOD_W, so DATA_W-1-cnt is simply the bitwise inverse of cnt.
    assign wr_idx = ~cnt_q;

    always_comb begin
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        data_d    = data_q;
        mod_d     = mod_q;
        val_d     = 1'b0;
        err_d     = 1'b0;
        shreg_nxt = shreg_q;
        shreg_nxt[wr_idx] = bus.data_i;

        if (bus.data_val_i) begin
            run_d = 1'b1;
            if (cnt_q == {MOD_W{1'b1}}) begin
                // Last bit of a word: emit it together with this bit and
                // start the next word clean, so back-to-back bits are not lost.
                data_d  = shreg_nxt;
                mod_d   = '0;
                val_d   = 1'b1;
                shreg_d = '0;
                cnt_d   = '0;
            end else begin
                shreg_d = shreg_nxt;
                cnt_d   = cnt_q + 1'b1;
            end
        end else if (run_q) begin
            run_d   = 1'b0;
            shreg_d = '0;
            cnt_d   = '0;
            if (cnt_q >= MOD_W'(MIN_BITS)) begin
                data_d = shreg_q;
                mod_d  = cnt_q;
                val_d  = 1'b1;
            end else if (cnt_q != '0) begin
                // Too short to be a legal frame: drop it, keep last word visible.
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            data_q  <= '0;
            mod_q   <= '0;
            val_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            data_q  <= data_d;
            mod_q   <= mod_d;
            val_q   <= val_d;
            err_q   <= err_d;
        end
    end

    assign bus.deser_data_o     = data_q;
    assign bus.deser_data_mod_o = mod_q;
    assign bus.deser_data_val_o = val_q;
    assign bus.err_o            = err_q;

endmodule

// File: tb/tb_deserializer.sv
// Testbench for deserializer: directed scenarios plus random runs; a
// bit-list reference model queues expected pulses, a negedge monitor
// checks every pulse the DUT produces against that queue.
module tb_deserializer;

    logic clk = 1'b0;
    logic srst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    deserializer_if #(.DATA_W(16), .MOD_W(4)) bus ();

    deserializer #(.DATA_W(16), .MOD_W(4), .MIN_BITS(3)) dut (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus)
    );

    typedef struct {
        bit          is_err;
        logic [15:0] data;
        logic [3:0]  mod;
        int          cyc;
    } exp_t;

    exp_t        expq[$];
    bit          rb[$];       // bits of the current run, in arrival order
    bit          run_act;
    logic [15:0] last_data;
    logic [3:0]  last_mod;

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    function automatic logic [15:0] pack_bits();
        logic [15:0] w = '0;
        for (int i = 0; i < rb.size(); i++) w[15-i] = rb[i];
        return w;
    endfunction

    // Present one serial cycle and predict what the next edge must produce.
    task automatic step(input bit v, input bit b);
        exp_t e;
        bus.data_val_i = v;
        bus.data_i     = v ? b : 1'($urandom_range(0, 1));
        e.cyc = cyc + 1;
        if (v) begin
            run_act = 1'b1;
            rb.push_back(b);
            if (rb.size() == 16) begin
                e.is_err = 0; e.data = pack_bits(); e.mod = 4'd0;
                last_data = e.data; last_mod = e.mod;
                expq.push_back(e);
                rb.delete();
            end
        end else if (run_act) begin
            run_act = 1'b0;
            if (rb.size() >= 3) begin
                e.is_err = 0; e.data = pack_bits(); e.mod = 4'(rb.size());
                last_data = e.data; last_mod = e.mod;
                expq.push_back(e);
            end else if (rb.size() > 0) begin
                e.is_err = 1; e.data = last_data; e.mod = last_mod;
                expq.push_back(e);
            end
            rb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [15:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) step(1'b1, w[15-i]);
    endtask

    task automatic do_reset();
        srst = 1'b1;
        bus.data_val_i = 1'b0;
        bus.data_i = 1'b0;
        @(posedge clk); #1;
        srst = 1'b0;
        rb.delete(); run_act = 0; last_data = '0; last_mod = '0;
        chk("rst_data", int'(bus.deser_data_o), 0);
        chk("rst_mod",  int'(bus.deser_data_mod_o), 0);
        chk("rst_val",  int'(bus.deser_data_val_o), 0);
        chk("rst_err",  int'(bus.err_o), 0);
    endtask

    // Monitor: every pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!srst) begin
            if (bus.deser_data_val_o && bus.err_o)
                chk("val_err_exclusive", 1, 0);
            if (bus.deser_data_val_o || bus.err_o) begin
                if (expq.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("pulse_kind",  int'(bus.err_o), int'(e.is_err));
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("pulse_data",  int'(bus.deser_data_o), int'(e.data));
                    chk("pulse_mod",   int'(bus.deser_data_mod_o), int'(e.mod));
                end
            end else if (expq.size() != 0 && expq[0].cyc < cyc) begin
                chk("missed_pulse", expq[0].cyc, cyc);
                void'(expq.pop_front());
            end
        end
    end

    initial begin
        bit b5[5];
        srst = 1'b1;
        bus.data_val_i = 1'b0;
        bus.data_i = 1'b0;
        run_act = 0; last_data = '0; last_mod = '0;
        @(posedge clk); #1;
        do_reset();

        // idle 10 cycles: outputs stay 0
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        chk("idle_data", int'(bus.deser_data_o), 0);
        chk("idle_mod",  int'(bus.deser_data_mod_o), 0);

        // full word, then run end with no extra pulse
        send_word(16'hA5C3, 16);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // partial 1,0,1,1,0 -> B000 / 5
        b5 = '{1, 0, 1, 1, 0};
        foreach (b5[i]) step(1'b1, b5[i]);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // short run -> err, data unchanged
        step(1'b1, 1'b1); step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("short_hold_data", int'(bus.deser_data_o), 16'hB000);
        chk("short_hold_mod",  int'(bus.deser_data_mod_o), 5);

        // continuous 37 bits
        send_word(16'h1234, 16);
        send_word(16'hFFFF, 16);
        b5 = '{1, 1, 0, 1, 0};
        foreach (b5[i]) step(1'b1, b5[i]);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // reset after 9 bits, then valid low: nothing emitted
        send_word(16'hCAFE, 9);
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        send_word(16'h0F0F, 16);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("after_rst_data", int'(bus.deser_data_o), 16'h0F0F);

        // random runs of assorted lengths with 1..3 idle gaps
        for (int r = 0; r < 60; r++) begin
            int len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) step(1'b1, 1'($urandom_range(0, 1)));
            for (int i = 0, g = $urandom_range(1, 3); i < g; i++) step(1'b0, 1'b0);
        end

        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("queue_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
